block_splitter: RTL and testbench
=================================

BLOCK_SPLITTER -- requirements
Module: block_splitter

Interface
REQ-001 Parameter MAX_BLOCKS, default 20: number of 512-bit blocks held in the padded input buffer.
REQ-002 Parameter IDX_W, default 5: width of the block index and count fields, equal to $clog2(MAX_BLOCKS+1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  padded buffer and block count valid.
REQ-006 in_ready  output  1  splitter can accept a new buffer.
REQ-007 padded_in  input  512*MAX_BLOCKS  padded message as produced by the padding stage; block 0 occupies the most significant 512 bits.
REQ-008 nblocks  input  IDX_W  number of leading blocks to emit, legal range 1..MAX_BLOCKS.
REQ-009 Wout[0:15]  output  16x32  current message block; Wout[0] is the most significant 32-bit word of the block.
REQ-010 blk_idx  output  IDX_W  index of the current block, starting at 0.
REQ-011 blk_first  output  1  current block is block 0 of its buffer.
REQ-012 blk_last  output  1  current block is the final block of its buffer.
REQ-013 out_valid  output  1  Wout, blk_idx, blk_first and blk_last are valid.
REQ-014 out_ready  input  1  downstream (w_comp/hash256 chain) accepts the current block.
REQ-015 err  output  1  one-cycle pulse flagging an illegal nblocks value.

Function
REQ-016 in_hs = in_valid&&in_ready and out_hs = out_valid&&out_ready; all transfers occur only on these handshakes.
REQ-017 The FSM has two states, IDLE and SEND; in_ready SHALL be 1 exactly when the state is IDLE, decoded combinationally from the state register.
REQ-018 IDLE, on in_hs with 1<=nblocks<=MAX_BLOCKS:
- padded_in is captured into an internal buffer;
- remaining count is set to nblocks;
- the FSM moves to SEND;
- block 0 is presented on the next cycle with out_valid=1, blk_idx=0, blk_first=1, and blk_last=(nblocks==1).
REQ-019 Latency from in_hs to first out_valid SHALL be exactly 1 cycle.
REQ-020 SEND, on out_hs with the block not last:
- the buffer shifts left by 512 bits;
- the next block appears on the following cycle;
- blk_idx increments and blk_first=0;
- blk_last=1 when blk_idx+1 == count-1;
- out_valid stays 1, giving 1 block/cycle while out_ready is held high.
REQ-021 SEND, on out_hs with blk_last=1: out_valid, blk_first and blk_last go to 0 next cycle, the FSM returns to IDLE, and in_ready=1 on that cycle.
REQ-022 While out_valid=1 and out_ready=0, Wout, blk_idx, blk_first and blk_last SHALL hold unchanged.
REQ-023 in_valid in SEND SHALL be ignored; a new buffer is never accepted and in_ready=0 until the last block is handed off.
REQ-024 in_hs with nblocks==0: no blocks are emitted, the FSM stays IDLE, and err pulses for 1 cycle on the next cycle.
REQ-025 in_hs with nblocks>MAX_BLOCKS: the count is clamped to MAX_BLOCKS, all MAX_BLOCKS blocks are emitted, and err pulses for 1 cycle on the next cycle.
REQ-026 With nblocks==1, the single block SHALL have blk_first=1 and blk_last=1 simultaneously.
REQ-027 Bits of padded_in beyond block nblocks-1 SHALL never appear on Wout.
REQ-028 blk_idx never exceeds MAX_BLOCKS-1, and the internal counter SHALL NOT wrap within one buffer.

Reset
REQ-029 rst_n=0 SHALL immediately force:
- FSM=IDLE, so in_ready=1;
- out_valid=0, blk_first=0, blk_last=0, err=0;
- blk_idx=0, Wout all zero, count=0.
REQ-030 Reset asserted mid-SEND SHALL abandon the current buffer; no further blocks from that buffer are emitted after rst_n deasserts.
REQ-031 After rst_n deasserts, the first in_hs SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-032 nblocks=2, block0 words = 32'h00000000..32'h0000000F, block1 = 32'h00000100..32'h0000010F, out_ready=1 -> out_valid cycles 1-2 after in_hs:
- cycle 1: Wout[0]=0, idx=0, first=1;
- cycle 2: Wout[0]=32'h100, idx=1, last=1;
- cycle 3: in_ready=1.
REQ-033 nblocks=20 with out_ready toggling 1,0,1,0 -> 20 distinct blocks in order, outputs held on every stall cycle, blk_last set only on idx=19.
REQ-034 nblocks=1 -> one block with first=last=1, then IDLE; a second buffer offered the next cycle is accepted.
REQ-035 nblocks=0 -> err=1 for one cycle, out_valid stays 0; nblocks=25 -> err=1 and exactly 20 blocks emitted.
REQ-036 rst_n pulsed low while blk_idx=3 of nblocks=8 -> out_valid=0 immediately; after release in_ready=1 and no stale blocks are emitted.
REQ-037 in_valid held high during SEND with a different buffer -> that buffer is ignored until the return to IDLE, then accepted, and its block 0 is emitted 1 cycle later.

Source files
------------

// File: rtl/block_splitter.sv
// ============================================================================
// Module   : block_splitter
// Brief    : Emits the leading 512-bit blocks of a padded message buffer, one
//            block per accepted out handshake, block 0 first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module block_splitter #(
  parameter int MAX_BLOCKS = 20,
  parameter int IDX_W      = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [512*MAX_BLOCKS-1:0] padded_in,
  input  logic [IDX_W-1:0]          nblocks,
  output logic [31:0]               Wout [0:15],
  output logic [IDX_W-1:0]          blk_idx,
  output logic                      blk_first,
  output logic                      blk_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err
);

  localparam int               c_BUF_W   = 512*MAX_BLOCKS;
  localparam logic [IDX_W-1:0] c_MAX_BLK = IDX_W'(MAX_BLOCKS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_BUF_W-1:0] r_buf;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_first;
  logic               r_last;
  logic               r_err;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_nb_zero;
  logic               w_nb_over;
  logic [IDX_W-1:0]   w_nb_clamp;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == SEND);
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = out_valid && out_ready;
  assign w_nb_zero  = (nblocks == '0);
  assign w_nb_over  = (nblocks > c_MAX_BLK);
  assign w_nb_clamp = w_nb_over ? c_MAX_BLK : nblocks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_hs && !w_nb_zero) w_state_nxt = SEND;
      SEND:    if (w_out_hs && r_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_in_hs && (w_nb_zero || w_nb_over);
      if (w_in_hs && !w_nb_zero) begin
        r_buf   <= padded_in;
        r_cnt   <= w_nb_clamp;
        r_idx   <= '0;
        r_first <= 1'b1;
        r_last  <= (w_nb_clamp == IDX_W'(1));
      end else if (w_out_hs) begin
        if (r_last) begin
          r_idx   <= '0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          // Not last implies r_idx <= r_cnt-2, so r_idx+2 cannot overflow.
          r_buf   <= r_buf << 512;
          r_idx   <= r_idx + IDX_W'(1);
          r_first <= 1'b0;
          r_last  <= ((r_idx + IDX_W'(2)) == r_cnt);
        end
      end
    end
  end

  // Words are blanked whenever no block is being presented.
  for (genvar g = 0; g < 16; g++) begin : g_word
    assign Wout[g] = out_valid ? r_buf[c_BUF_W-1-32*g -: 32] : 32'd0;
  end

  assign blk_idx   = r_idx;
  assign blk_first = r_first;
  assign blk_last  = r_last;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_block_splitter.sv
// ============================================================================
// Module   : tb_block_splitter
// Brief    : Directed self-checking bench for block_splitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_block_splitter;

  localparam int MAXB  = 20;
  localparam int IW    = 5;
  localparam int BUF_W = 512*MAXB;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BUF_W-1:0] padded_in;
  logic [IW-1:0]    nblocks;
  logic [31:0]      Wout [0:15];
  logic [IW-1:0]    blk_idx;
  logic             blk_first;
  logic             blk_last;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  int n_vec = 0;
  int n_bad = 0;

  block_splitter #(.MAX_BLOCKS(MAXB), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .padded_in (padded_in),
    .nblocks   (nblocks),
    .Wout      (Wout),
    .blk_idx   (blk_idx),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int seed, input int b, input int w);
    return (32'(seed) << 24) | (32'(b) << 8) | 32'(w);
  endfunction

  function automatic logic [BUF_W-1:0] mkbuf(input int seed);
    logic [BUF_W-1:0] v;
    v = '0;
    for (int b = 0; b < MAXB; b++)
      for (int w = 0; w < 16; w++)
        v[BUF_W-1-(b*512+w*32) -: 32] = word(seed, b, w);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one buffer for a single cycle (the splitter is IDLE here).
  task automatic load(input int seed, input int nb);
    in_valid  = 1'b1;
    padded_in = mkbuf(seed);
    nblocks   = IW'(nb);
    step();
    in_valid  = 1'b0;
  endtask

  // Consume nexp blocks, optionally stalling every other cycle.
  task automatic drain(input int seed, input int nexp, input bit tog);
    int  k;
    int  cyc;
    bit  rdy;
    k   = 0;
    cyc = 0;
    while (k < nexp && cyc < 200) begin
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("blk_idx",   64'(blk_idx),   64'(k));
      chk("Wout0",     64'(Wout[0]),   64'(word(seed, k, 0)));
      chk("Wout7",     64'(Wout[7]),   64'(word(seed, k, 7)));
      chk("Wout15",    64'(Wout[15]),  64'(word(seed, k, 15)));
      chk("blk_first", 64'(blk_first), 64'(k == 0));
      chk("blk_last",  64'(blk_last),  64'(k == nexp-1));
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      rdy       = tog ? (cyc % 2 == 0) : 1'b1;
      out_ready = rdy;
      step();
      if (rdy) k++;
      cyc++;
    end
    if (k < nexp) chk("drain_timeout", 64'(k), 64'(nexp));
    out_ready = 1'b1;
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_ready", 64'(in_ready),  64'd1);
    chk("done_first", 64'(blk_first), 64'd0);
    chk("done_last",  64'(blk_last),  64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    padded_in = '0;
    nblocks   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_idx",       64'(blk_idx),   64'd0);
    chk("rst_first",     64'(blk_first), 64'd0);
    chk("rst_last",      64'(blk_last),  64'd0);
    chk("rst_wout0",     64'(Wout[0]),   64'd0);
    step();
    step();
    rst_n = 1'b1;

    // Two-block buffer with the canonical word pattern.
    load(0, 2);
    chk("b2_c1_w0",    64'(Wout[0]),   64'h0);
    chk("b2_c1_w15",   64'(Wout[15]),  64'hF);
    chk("b2_c1_idx",   64'(blk_idx),   64'd0);
    chk("b2_c1_first", 64'(blk_first), 64'd1);
    chk("b2_c1_err",   64'(err),       64'd0);
    step();
    chk("b2_c2_w0",    64'(Wout[0]),   64'h100);
    chk("b2_c2_idx",   64'(blk_idx),   64'd1);
    chk("b2_c2_last",  64'(blk_last),  64'd1);
    step();
    chk("b2_c3_ready", 64'(in_ready),  64'd1);
    chk("b2_c3_valid", 64'(out_valid), 64'd0);

    // Full buffer under alternating backpressure.
    load(1, 20);
    drain(1, 20, 1'b1);

    // Single-block buffers back to back.
    load(2, 1);
    drain(2, 1, 1'b0);
    load(3, 1);
    drain(3, 1, 1'b0);

    // Zero count: error pulse, nothing emitted.
    load(4, 0);
    chk("nb0_err",   64'(err),       64'd1);
    chk("nb0_valid", 64'(out_valid), 64'd0);
    step();
    chk("nb0_err_clr", 64'(err),       64'd0);
    chk("nb0_valid2",  64'(out_valid), 64'd0);
    chk("nb0_ready",   64'(in_ready),  64'd1);

    // Oversized count clamps to MAX_BLOCKS.
    load(5, 25);
    chk("nb25_err", 64'(err), 64'd1);
    drain(5, 20, 1'b0);
    chk("nb25_err_clr", 64'(err), 64'd0);

    // Reset mid-buffer.
    load(6, 8);
    step();
    step();
    step();
    chk("mid_idx", 64'(blk_idx), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd1);
    chk("mid_rst_idx",   64'(blk_idx),   64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      chk("post_rst_ready", 64'(in_ready),  64'd1);
    end

    // New buffer held on in_valid during SEND is taken only after the last block.
    in_valid  = 1'b1;
    padded_in = mkbuf(7);
    nblocks   = IW'(3);
    step();
    padded_in = mkbuf(8);
    nblocks   = IW'(2);
    drain(7, 3, 1'b0);
    step();
    in_valid = 1'b0;
    drain(8, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
